au_wb_buffer: RTL and testbench

AU_WB_BUFFER -- requirements
Module: au_wb_buffer

---
 rtl/au_wb_buffer.sv | 103 ++++++++++
 tb/tb_au_wb_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/au_wb_buffer.sv
// Write-back result buffer between arithmetic unit and register file: circular FIFO.
// Optional bypass lookup of buffered results compiled with `define AU_WB_BYPASS_EN.
module au_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_wdata,
    input  logic [4:0]                 in_rd,
    input  logic                       in_wen,
    input  logic                       flush,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [DATA_W-1:0]          wb_wdata,
    output logic [4:0]                 wb_rd,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [4:0]                 byp_rs,
    output logic                       byp_hit,
    output logic [DATA_W-1:0]          byp_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [4:0]        rd_mem   [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    assign count    = count_q;
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign wb_valid = (count_q != '0);
    assign wb_wdata = data_mem[head];
    assign wb_rd    = rd_mem[head];

    // Handshakes with in_wen=0 or in_rd=0 are accepted but never occupy an entry.
    assign push = in_valid & in_ready & in_wen & (in_rd != 5'd0) & ~flush;
    assign pop  = wb_valid & wb_ready & ~flush;

    // Storage is cleared on reset so the head outputs read 0 out of reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                rd_mem[i]   <= '0;
            end
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_mem[tail] <= in_wdata;
                rd_mem[tail]   <= in_rd;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef AU_WB_BYPASS_EN
    logic [PTR_W-1:0] slot;

    // Walk entries oldest to youngest so the last match wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        slot     = '0;
        if (byp_rs != 5'd0) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot = head + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (rd_mem[slot] == byp_rs)) begin
                    byp_hit  = 1'b1;
                    byp_data = data_mem[slot];
                end
            end
        end
    end
`else
    logic unused_byp_rs;

    assign unused_byp_rs = ^byp_rs;
    assign byp_hit       = 1'b0;
    assign byp_data      = '0;
`endif

endmodule

// File: tb/tb_au_wb_buffer.sv
// Randomized bench for au_wb_buffer against a queue-based reference model.
// Bypass expectations follow whether AU_WB_BYPASS_EN is defined for the build.
module tb_au_wb_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_wdata;
    logic [4:0]        in_rd;
    logic              in_wen;
    logic              flush;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_wdata;
    logic [4:0]        wb_rd;
    logic [2:0]        count;
    logic [4:0]        byp_rs;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    au_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_wdata(in_wdata),
        .in_rd(in_rd), .in_wen(in_wen), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wdata(wb_wdata),
        .wb_rd(wb_rd), .count(count),
        .byp_rs(byp_rs), .byp_hit(byp_hit), .byp_data(byp_data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t model_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic              exp_hit;
        logic [DATA_W-1:0] exp_data;
        exp_hit  = 1'b0;
        exp_data = '0;
        check("count", 64'(count), 64'(model_q.size()));
        check("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
        check("wb_valid", 64'(wb_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("wb_rd", 64'(wb_rd), 64'(model_q[0].rd));
            check("wb_wdata", 64'(wb_wdata), 64'(model_q[0].data));
        end
`ifdef AU_WB_BYPASS_EN
        if (byp_rs != 5'd0) begin
            foreach (model_q[i]) begin
                if (model_q[i].rd == byp_rs) begin
                    exp_hit  = 1'b1;
                    exp_data = model_q[i].data;
                end
            end
        end
`endif
        check("byp_hit", 64'(byp_hit), 64'(exp_hit));
        check("byp_data", 64'(byp_data), 64'(exp_data));
    endtask

    // Drive one cycle of inputs, compare outputs, advance the model over the edge.
    task automatic step(input logic v, input logic [4:0] rd, input logic [DATA_W-1:0] d,
                        input logic wen, input logic rdy, input logic fl, input logic [4:0] rs);
        logic do_push;
        logic do_pop;
        entry_t e;
        in_valid = v;
        in_rd    = rd;
        in_wdata = d;
        in_wen   = wen;
        wb_ready = rdy;
        flush    = fl;
        byp_rs   = rs;
        #1;
        check_all();
        do_pop  = (model_q.size() != 0) && rdy && !fl;
        do_push = v && (model_q.size() < DEPTH) && wen && (rd != 5'd0) && !fl;
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.rd   = rd;
                e.data = d;
                model_q.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST     = 1'b0;
        in_valid = 1'b0;
        in_wdata = '0;
        in_rd    = '0;
        in_wen   = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        byp_rs   = 5'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_wdata", 64'(wb_wdata), 64'd0);
        check("rst_wb_rd", 64'(wb_rd), 64'd0);
        check("rst_byp_hit", 64'(byp_hit), 64'd0);
        check("rst_byp_data", 64'(byp_data), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Single result, one-cycle latency, popped on the following edge.
        step(1, 5'd5, 32'hDEADBEEF, 1, 1, 0, 0);
        check("t1_valid", 64'(wb_valid), 64'd1);
        check("t1_rd", 64'(wb_rd), 64'd5);
        check("t1_data", 64'(wb_wdata), 64'hDEADBEEF);
        step(0, 0, 0, 1, 1, 0, 0);
        check("t1_drained", 64'(count), 64'd0);

        // Fill with wb_ready=0, then hold a fifth result.
        for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 32'(32'h100 + i), 1, 0, 0, 0);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        step(1, 5'd9, 32'h999, 1, 0, 0, 0);
        check("full_held", 64'(count), 64'd4);
        check("full_head_stable", 64'(wb_wdata), 64'h100);
        step(1, 5'd9, 32'h999, 1, 1, 0, 0);
        check("full_pop_only", 64'(count), 64'd3);
        step(1, 5'd9, 32'h999, 1, 0, 0, 0);
        check("full_push_next", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 0);
        check("drained", 64'(count), 64'd0);

        // Dropped handshakes.
        step(1, 5'd0, 32'h1111, 1, 0, 0, 0);
        step(1, 5'd3, 32'h2222, 0, 0, 0, 0);
        check("drop_count", 64'(count), 64'd0);
        check("drop_valid", 64'(wb_valid), 64'd0);

        // Ten results streamed through so both pointers wrap.
        for (int i = 0; i < 10; i++) step(1, 5'(i + 10), 32'(i * 7 + 1), 1, (i % 3) != 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, 0);
        check("wrap_drained", 64'(count), 64'd0);

        // Flush beats a concurrent push.
        for (int i = 0; i < 3; i++) step(1, 5'(i + 1), 32'(i), 1, 0, 0, 0);
        step(1, 5'd4, 32'h44, 1, 1, 1, 0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(wb_valid), 64'd0);

        // Bypass lookup: youngest matching entry wins.
        step(1, 5'd7, 32'd1, 1, 0, 0, 0);
        step(1, 5'd7, 32'd2, 1, 0, 0, 7);
        byp_rs = 5'd7;
        #1;
`ifdef AU_WB_BYPASS_EN
        check("byp_young_hit", 64'(byp_hit), 64'd1);
        check("byp_young_data", 64'(byp_data), 64'd2);
`else
        check("byp_off_hit", 64'(byp_hit), 64'd0);
        check("byp_off_data", 64'(byp_data), 64'd0);
`endif
        byp_rs = 5'd0;
        #1;
        check("byp_rs0_hit", 64'(byp_hit), 64'd0);

        // Asynchronous reset mid-stream.
        in_valid = 1'b0;
        nRST     = 1'b0;
        #1;
        check("arst_valid", 64'(wb_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        model_q.delete();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        step(1, 5'd12, 32'hCAFE, 1, 0, 0, 0);
        check("post_rst_rd", 64'(wb_rd), 64'd12);
        check("post_rst_data", 64'(wb_wdata), 64'hCAFE);

        // Random traffic with a small register pool to exercise bypass matches.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 6)),
                 32'($urandom),
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0,
                 5'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
